// File: rtl/bitbang_spi_master.sv
// Bit-banged SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
// Pulls words from a show-ahead source (empty/get) and pushes each received
// word out with a one-cycle put pulse. Bit timing comes from an external
// half-bit step enable, so two steps make one SPI bit.
module bitbang_spi_master #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  input  logic [W-1:0] in,
  output logic         get,
  input  logic         empty,
  output logic [W-1:0] out,
  output logic         put,
  output logic         spi_cs_n,
  output logic         spi_clock,
  output logic         spi_mosi,
  input  logic         spi_miso
);

  // Counter needs to hold the value W itself, hence one bit more than log2(W).
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   sr, sr_next;
  logic           sample, sample_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [W-1:0]   out_next;
  logic           put_next;
  logic           cs_next;
  logic           clk_next;
  logic           last_half;

  // The final falling half of a word is the only point inside a transfer
  // where the next word may be taken, which keeps chip select low between
  // back-to-back words.
  assign last_half = (state == XFER) && spi_clock && (cnt == CNT_ONE);
  assign get       = step && !empty && ((state == IDLE) || last_half);

  // MOSI is the shift register MSB; the register only moves on falling
  // halves or on load, so MOSI is stable at every SPI clock rise.
  assign spi_mosi = sr[W-1];

  // State register with synchronous reset; a reset mid-word simply abandons
  // the word, so no put is ever produced for it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      sample    <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      put       <= 1'b0;
      spi_cs_n  <= 1'b1;
      spi_clock <= 1'b0;
    end else begin
      state     <= state_next;
      sr        <= sr_next;
      sample    <= sample_next;
      cnt       <= cnt_next;
      out       <= out_next;
      put       <= put_next;
      spi_cs_n  <= cs_next;
      spi_clock <= clk_next;
    end
  end

  // Next-state logic: everything holds unless step is high; put defaults low
  // so it can only ever last a single cycle.
  always_comb begin
    state_next  = state;
    sr_next     = sr;
    sample_next = sample;
    cnt_next    = cnt;
    out_next    = out;
    put_next    = 1'b0;
    cs_next     = spi_cs_n;
    clk_next    = spi_clock;

    if (step) begin
      case (state)
        IDLE: begin
          cs_next  = 1'b1;
          clk_next = 1'b0;
          if (get) begin
            sr_next    = in;
            cnt_next   = CNT_FULL;
            cs_next    = 1'b0;
            state_next = XFER;
          end
        end

        XFER: begin
          if (!spi_clock) begin
            // Rising half: slave sees a stable MOSI, we capture MISO.
            clk_next    = 1'b1;
            sample_next = spi_miso;
          end else if (cnt != CNT_ONE) begin
            // Falling half mid-word: shift the captured bit in, next bit out.
            clk_next = 1'b0;
            sr_next  = {sr[W-2:0], sample};
            cnt_next = cnt - CNT_ONE;
          end else begin
            // Last falling half: deliver the word, then chain or deselect.
            clk_next = 1'b0;
            out_next = {sr[W-2:0], sample};
            put_next = 1'b1;
            if (get) begin
              sr_next  = in;
              cnt_next = CNT_FULL;
            end else begin
              cs_next    = 1'b1;
              state_next = IDLE;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitbang_spi_master.sv
// Directed self-checking bench for bitbang_spi_master (W=8, step every 4 clocks).
module tb_bitbang_spi_master;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         step  = 1'b0;
  logic [W-1:0] in_word;
  logic         get;
  logic         empty;
  logic [W-1:0] out_word;
  logic         put;
  logic         spi_cs_n;
  logic         spi_clock;
  logic         spi_mosi;
  logic         spi_miso;

  // Word source: a small ring written by the stimulus and popped on get.
  logic [W-1:0] src_mem [0:15];
  int           src_wr = 0;
  int           src_rd = 0;

  logic loopback    = 1'b1;
  logic miso_val    = 1'b0;
  logic step_enable = 1'b1;
  logic get_seen    = 1'b0;
  int   step_div    = 0;

  // Observation record filled by the monitor.
  int   cycle = 0;
  int   get_cycles[$];
  int   put_cycles[$];
  logic [W-1:0] put_words[$];
  logic mosi_at_rise[$];
  int   cs_fall_total = 0;
  int   cs_rise_total = 0;
  int   cs_low_cycles = 0;
  int   clk_high_cycles = 0;
  int   mosi_high_sel_cycles = 0;
  logic prev_clk = 1'b0;
  logic prev_cs  = 1'b1;

  int check_count = 0;
  int pass_count  = 0;

  assign empty    = (src_rd == src_wr);
  assign in_word  = src_mem[src_rd % 16];
  assign spi_miso = loopback ? spi_mosi : miso_val;

  bitbang_spi_master #(.W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .step      (step),
    .in        (in_word),
    .get       (get),
    .empty     (empty),
    .out       (out_word),
    .put       (put),
    .spi_cs_n  (spi_cs_n),
    .spi_clock (spi_clock),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  // 10 ns system clock.
  initial forever #5 clock = ~clock;

  // Strobe timer (every 4th clock) and source pop, both just after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (get_seen) src_rd = src_rd + 1;
      step_div = (step_div + 1) % 4;
      step = step_enable && (step_div == 0);
    end
  end

  // Monitor samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      cycle = cycle + 1;
      get_seen = get;
      if (get === 1'b1) get_cycles.push_back(cycle);
      if (put === 1'b1) begin
        put_words.push_back(out_word);
        put_cycles.push_back(cycle);
      end
      if (spi_clock && !prev_clk) mosi_at_rise.push_back(spi_mosi);
      if (!spi_cs_n && prev_cs) cs_fall_total = cs_fall_total + 1;
      if (spi_cs_n && !prev_cs) cs_rise_total = cs_rise_total + 1;
      if (!spi_cs_n) cs_low_cycles = cs_low_cycles + 1;
      if (spi_clock) clk_high_cycles = clk_high_cycles + 1;
      if (!spi_cs_n && spi_mosi) mosi_high_sel_cycles = mosi_high_sel_cycles + 1;
      prev_clk = spi_clock;
      prev_cs  = spi_cs_n;
    end
  end

  // Hard stop if something hangs beyond every bounded wait.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count = check_count + 1;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    else
      pass_count = pass_count + 1;
  endtask

  task automatic pushWord(input logic [W-1:0] w);
    @(posedge clock);
    #2;
    src_mem[src_wr % 16] = w;
    src_wr = src_wr + 1;
  endtask

  task automatic waitPuts(input int target, input int limit, input string tag);
    int k = 0;
    while (put_words.size() < target && k < limit) begin
      @(posedge clock);
      k++;
    end
    checkOutput(tag, 32'(put_words.size() >= target), 32'd1);
  endtask

  task automatic waitRises(input int target, input int limit, input string tag);
    int k = 0;
    while (mosi_at_rise.size() < target && k < limit) begin
      @(posedge clock);
      k++;
    end
    checkOutput(tag, 32'(mosi_at_rise.size() >= target), 32'd1);
  endtask

  task automatic applyStimulus();
    int gb, pb, rb, cfb, crb, clb, chb, mhb;
    logic [W-1:0] b;

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_cs_n",  spi_cs_n,  1);
    checkOutput("rst_clock", spi_clock, 0);
    checkOutput("rst_mosi",  spi_mosi,  0);
    checkOutput("rst_put",   put,       0);
    checkOutput("rst_out",   out_word,  0);
    checkOutput("rst_get",   get,       0);

    // Empty source with step running: nothing happens
    gb = get_cycles.size(); pb = put_words.size();
    clb = cs_low_cycles; chb = clk_high_cycles;
    repeat (100) @(posedge clock);
    checkOutput("empty_gets",   get_cycles.size() - gb, 0);
    checkOutput("empty_puts",   put_words.size() - pb,  0);
    checkOutput("empty_cs_low", cs_low_cycles - clb,    0);
    checkOutput("empty_clk_hi", clk_high_cycles - chb,  0);

    // Single word 0x48 in loopback
    gb = get_cycles.size(); pb = put_words.size(); rb = mosi_at_rise.size();
    cfb = cs_fall_total;
    pushWord(8'h48);
    waitPuts(pb + 1, 200, "one_put_seen");
    repeat (8) @(posedge clock);
    checkOutput("one_gets",    get_cycles.size() - gb,   1);
    checkOutput("one_cs_fall", cs_fall_total - cfb,      1);
    checkOutput("one_rises",   mosi_at_rise.size() - rb, 8);
    b = '0;
    for (int i = 0; i < 8; i++) b = {b[W-2:0], mosi_at_rise[rb + i]};
    checkOutput("one_mosi_bits", b, 8'h48);
    checkOutput("one_puts",    put_words.size() - pb, 1);
    checkOutput("one_out",     put_words[pb], 8'h48);
    // The put is registered: it is visible one clock after the step that
    // finishes the word, and that step comes 64 clocks after the get.
    checkOutput("one_latency", put_cycles[pb] - 1 - get_cycles[gb], 64);
    @(negedge clock);
    checkOutput("one_idle_cs",  spi_cs_n,  1);
    checkOutput("one_idle_clk", spi_clock, 0);

    // Two words "He" back to back, no CS gap
    gb = get_cycles.size(); pb = put_words.size(); rb = mosi_at_rise.size();
    cfb = cs_fall_total; crb = cs_rise_total;
    pushWord(8'h48);
    pushWord(8'h65);
    waitPuts(pb + 2, 400, "he_puts_seen");
    repeat (8) @(posedge clock);
    checkOutput("he_gets",    get_cycles.size() - gb,   2);
    checkOutput("he_cs_fall", cs_fall_total - cfb,      1);
    checkOutput("he_cs_rise", cs_rise_total - crb,      1);
    checkOutput("he_rises",   mosi_at_rise.size() - rb, 16);
    checkOutput("he_out0",    put_words[pb],     8'h48);
    checkOutput("he_out1",    put_words[pb + 1], 8'h65);
    checkOutput("he_spacing", put_cycles[pb + 1] - put_cycles[pb], 64);
    checkOutput("he_get2_at_put_step", get_cycles[gb + 1], put_cycles[pb] - 1);

    // MISO tied high, transmit 0x00
    loopback = 1'b0; miso_val = 1'b1;
    pb = put_words.size(); mhb = mosi_high_sel_cycles;
    pushWord(8'h00);
    waitPuts(pb + 1, 200, "ones_put_seen");
    repeat (8) @(posedge clock);
    checkOutput("ones_out",     put_words[pb], 8'hFF);
    checkOutput("ones_mosi_hi", mosi_high_sel_cycles - mhb, 0);
    loopback = 1'b1; miso_val = 1'b0;

    // Step held low with data waiting: nothing moves until step resumes
    @(posedge clock);
    #2 step_enable = 1'b0;
    repeat (2) @(posedge clock);
    gb = get_cycles.size(); pb = put_words.size();
    clb = cs_low_cycles; chb = clk_high_cycles;
    pushWord(8'hA5);
    repeat (50) @(posedge clock);
    checkOutput("nostep_gets",   get_cycles.size() - gb, 0);
    checkOutput("nostep_cs_low", cs_low_cycles - clb,    0);
    checkOutput("nostep_clk_hi", clk_high_cycles - chb,  0);
    checkOutput("nostep_puts",   put_words.size() - pb,  0);
    @(posedge clock);
    #2 step_enable = 1'b1;
    waitPuts(pb + 1, 200, "nostep_put_seen");
    checkOutput("nostep_out", put_words[pb], 8'hA5);

    // Reset after the 3rd SPI clock rise aborts the word
    repeat (8) @(posedge clock);
    pb = put_words.size(); rb = mosi_at_rise.size();
    pushWord(8'h3C);
    waitRises(rb + 3, 300, "abort_rise3_seen");
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checkOutput("abort_cs_n",  spi_cs_n,  1);
    checkOutput("abort_clock", spi_clock, 0);
    checkOutput("abort_put",   put,       0);
    checkOutput("abort_out",   out_word,  0);
    checkOutput("abort_mosi",  spi_mosi,  0);
    repeat (20) @(posedge clock);
    checkOutput("abort_no_put", put_words.size() - pb, 0);
    gb = get_cycles.size();
    pushWord(8'h5A);
    waitPuts(pb + 1, 200, "after_abort_put_seen");
    checkOutput("after_abort_gets", get_cycles.size() - gb, 1);
    checkOutput("after_abort_out",  put_words[pb], 8'h5A);
    checkOutput("after_abort_lat",  put_cycles[pb] - 1 - get_cycles[gb], 64);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) src_mem[i] = '0;
    $display("[TB] bitbang_spi_master directed test start");
    applyStimulus();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
